load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits between the execute stage and data_memory: takes RV32I load/store requests, drives data_memory's word-only port (A, WD, WE, RD), and returns load data or an error.
- Handles byte/halfword extraction with sign or zero extension.
- Handles sub-word stores by read-modify-write, since data_memory has no byte enables.
- Detects misaligned, out-of-range and unsupported accesses.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in data_memory; word index >= DEPTH_WORDS is out of range.

Ports:
clk  input  1  single clock; all state updates on posedge.
rst_n  input  1  asynchronous, active-low reset.
req_valid  input  1  request present.
req_ready  output  1  high only in IDLE; request accepted when req_valid && req_ready.
req_we  input  1  1 = store, 0 = load.
req_funct3  input  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only).
req_addr  input  32  byte address.
req_wdata  input  32  store data; low byte/half used for SB/SH.
resp_valid  output  1  one-cycle pulse, no backpressure.
resp_rdata  output  32  load result, valid with resp_valid; 0 for stores and errors.
resp_err  output  1  valid with resp_valid: misaligned, out-of-range or unsupported.
mem_a  output  32  word index to data_memory: {2'b00, addr[31:2]}.
mem_wd  output  32  write data to data_memory.
mem_we  output  1  write enable to data_memory.
mem_rd  input  32  combinational read data from data_memory; valid only when mem_we = 0.

Behaviour:
- Reset: asynchronous. state = IDLE, req_ready = 1, resp_valid = 0, resp_err = 0, resp_rdata = 0, mem_we = 0, mem_a = 0, mem_wd = 0.
- Reset asserted mid-operation aborts immediately. mem_we drops asynchronously. A pending RMW never writes.
- States: IDLE, LOAD, WRITE, RMW_READ, RMW_WRITE, RESP. Add LOAD_HI with LSU_MISALIGN_EN.
- On accept (edge E0), latch we, funct3, addr, wdata, then branch:
  - Error (see checks below) -> RESP with err = 1. No memory access, mem_we stays 0.
  - Load -> LOAD.
  - SW -> WRITE.
  - SB/SH -> RMW_READ.
- Error checks:
  - Unsupported funct3: 011, 110, 111, and BU/HU with we = 1.
  - Misaligned: H/HU with addr[0] = 1; W with addr[1:0] != 0.
  - Out of range: addr[31:2] >= DEPTH_WORDS.
- LOAD: mem_a = word index, mem_we = 0. At E1, capture the selected lane, extended per funct3. Lane = addr[1:0] for bytes, addr[1] for halves; little-endian. Then -> RESP.
- WRITE: mem_we = 1 for exactly one cycle, mem_wd = wdata. data_memory writes at E1. Then -> RESP.
- RMW_READ: mem_we = 0. At the edge, register the merge of mem_rd with the new byte/half in the addressed lane. Then -> RMW_WRITE.
- RMW_WRITE: mem_we = 1, mem_wd = merged word. Then -> RESP.
- RESP: resp_valid = 1 for one cycle, then -> IDLE. req_ready returns high the following cycle.
- Latency, accept edge to resp_valid cycle:
  - Error: 1 cycle.
  - Load / SW: 2 cycles.
  - SB/SH: 3 cycles.
- mem_we is never asserted outside WRITE/RMW_WRITE. In all other states mem_wd = 0.
- No request is accepted outside IDLE. req_* may change freely while req_ready = 0.

Optional Feature:
- Macro: LSU_MISALIGN_EN.
- Defined: misaligned LW/LH/LHU are not errors.
  - LOAD reads word N and stores it in a low register, then goes to LOAD_HI.
  - LOAD_HI reads word N+1 and assembles the result from byte offset addr[1:0] across both words.
  - Result is extended per funct3, then -> RESP. Load latency becomes 3 cycles.
  - If word N+1 >= DEPTH_WORDS, the access is an error detected at accept, with no memory access.
  - Misaligned stores remain errors.
- Undefined: LOAD_HI is absent and all misaligned accesses are errors.

Decomposition:
- Shared package/header lsu_pkg:
  - funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State encodings.
  - Default DEPTH_WORDS.
- One sub-module, lsu_align (combinational):
  - Lane extract + sign/zero extend for loads.
  - Lane merge for sub-word stores.
  - Misalignment detection.
- The FSM stays in load_store_unit.

Test Plan:
- Preload word1 = 0x8899AABB:
  - LB addr 0x5 -> resp_rdata = 0xFFFFFFAA, err = 0, resp_valid 2 cycles after accept.
  - LBU addr 0x5 -> resp_rdata = 0x000000AA.
  - LHU addr 0x6 -> resp_rdata = 0x00008899.
- SB addr 0x6, wdata 0x11 -> word1 becomes 0x8811AABB. mem_we high exactly 1 cycle. resp_valid 3 cycles after accept, rdata = 0.
- SW addr 0x8, wdata 0x44332211 -> word2 = 0x44332211. Then LW addr 0x8 -> 0x44332211.
- Misaligned LW addr 0x6:
  - Without macro: err = 1, rdata = 0, mem_we never high, latency 1.
  - With LSU_MISALIGN_EN and word1/word2 as above: rdata = 0x22118899, latency 3.
- LW addr 0x1000 (word 1024) -> err = 1, no memory access.
- funct3 = 011 -> err = 1, no memory access.
- SH addr 0x4: drop rst_n during RMW_READ -> mem_we never asserted, word1 unchanged, req_ready = 1 after release.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states and default depth.
// LSU_MISALIGN_EN adds the LOAD_HI state used for loads that straddle two words.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int LSU_DEPTH_WORDS = 1024;

`ifdef LSU_MISALIGN_EN
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_WRITE     = 3'd2,
    ST_RMW_READ  = 3'd3,
    ST_RMW_WRITE = 3'd4,
    ST_RESP      = 3'd5,
    ST_LOAD_HI   = 3'd6
  } lsu_state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_WRITE     = 3'd2,
    ST_RMW_READ  = 3'd3,
    ST_RMW_WRITE = 3'd4,
    ST_RESP      = 3'd5
  } lsu_state_t;
`endif

  // Reserved funct3 codes, plus unsigned widths that only make sense for loads.
  function automatic logic is_unsupported(input logic [2:0] funct3, input logic we);
    return (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111) ||
           (we && ((funct3 == F3_BU) || (funct3 == F3_HU)));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load extract/extend, sub-word store merge, misalignment check.
// Loads shift the 64-bit pair {word_hi, word_lo}; word_hi only matters for straddling loads.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  op_funct3,
  input  logic [1:0]  op_offset,
  input  logic [31:0] ld_word_lo,
  input  logic [31:0] ld_word_hi,
  output logic [31:0] ld_data,
  input  logic [15:0] st_data,
  input  logic [31:0] st_word,
  output logic [31:0] st_merged,
  input  logic [2:0]  chk_funct3,
  input  logic [1:0]  chk_offset,
  output logic        chk_misaligned
);

  logic [31:0] shifted;

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    ld_data        = '0;
    st_merged      = st_word;
    chk_misaligned = 1'b0;
    shifted        = 32'({ld_word_hi, ld_word_lo} >> {op_offset, 3'b000});

    case (op_funct3)
      F3_B:    ld_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   ld_data = {24'h0, shifted[7:0]};
      F3_H:    ld_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   ld_data = {16'h0, shifted[15:0]};
      F3_W:    ld_data = shifted;
      default: ld_data = '0;
    endcase

    if (op_funct3 == F3_B)
      st_merged[{op_offset, 3'b000} +: 8] = st_data[7:0];
    else if (op_funct3 == F3_H)
      st_merged[{op_offset[1], 4'b0000} +: 16] = st_data;

    case (chk_funct3)
      F3_H, F3_HU: chk_misaligned = chk_offset[0];
      F3_W:        chk_misaligned = (chk_offset != 2'b00);
      default:     chk_misaligned = 1'b0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a word-only data memory; sub-word stores use read-modify-write.
// Define LSU_MISALIGN_EN to let misaligned LW/LH/LHU complete as two-word reads.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DEPTH_WORDS = LSU_DEPTH_WORDS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  input  logic [31:0] mem_rd
);

  lsu_state_t  state;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [31:0] wdata_q;

  logic [31:0] req_word;
  logic        req_misaligned;
  logic        misalign_err;
  logic        range_err;
  logic        req_err;
  logic [31:0] word_lo;
  logic [31:0] word_hi;
  logic [31:0] load_data;
  logic [31:0] merged;

  assign req_word = {2'b00, req_addr[31:2]};

`ifdef LSU_MISALIGN_EN
  logic        req_split;
  logic        split_q;
  logic [31:0] lo_q;

  assign req_split    = req_misaligned && !req_we;
  assign misalign_err = req_misaligned && req_we;
  assign range_err    = (req_word >= 32'(DEPTH_WORDS)) ||
                        (req_split && ((req_word + 32'd1) >= 32'(DEPTH_WORDS)));
  assign word_lo      = (state == ST_LOAD_HI) ? lo_q : mem_rd;
  assign word_hi      = (state == ST_LOAD_HI) ? mem_rd : 32'h0;
`else
  assign misalign_err = req_misaligned;
  assign range_err    = (req_word >= 32'(DEPTH_WORDS));
  assign word_lo      = mem_rd;
  assign word_hi      = 32'h0;
`endif

  assign req_err = is_unsupported(req_funct3, req_we) || misalign_err || range_err;

  lsu_align u_align (
    .op_funct3      (f3_q),
    .op_offset      (off_q),
    .ld_word_lo     (word_lo),
    .ld_word_hi     (word_hi),
    .ld_data        (load_data),
    .st_data        (wdata_q[15:0]),
    .st_word        (mem_rd),
    .st_merged      (merged),
    .chk_funct3     (req_funct3),
    .chk_offset     (req_addr[1:0]),
    .chk_misaligned (req_misaligned)
  );

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      mem_we     <= 1'b0;
      mem_a      <= '0;
      mem_wd     <= '0;
      f3_q       <= '0;
      off_q      <= '0;
      wdata_q    <= '0;
`ifdef LSU_MISALIGN_EN
      split_q    <= 1'b0;
      lo_q       <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            f3_q      <= req_funct3;
            off_q     <= req_addr[1:0];
            wdata_q   <= req_wdata;
`ifdef LSU_MISALIGN_EN
            split_q   <= req_split;
`endif
            if (req_err) begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              mem_a <= req_word;
              if (!req_we) begin
                state <= ST_LOAD;
              end else if (req_funct3 == F3_W) begin
                state  <= ST_WRITE;
                mem_we <= 1'b1;
                mem_wd <= req_wdata;
              end else begin
                state <= ST_RMW_READ;
              end
            end
          end
        end

        ST_LOAD: begin
`ifdef LSU_MISALIGN_EN
          if (split_q) begin
            lo_q  <= mem_rd;
            mem_a <= mem_a + 32'd1;
            state <= ST_LOAD_HI;
          end else begin
            resp_rdata <= load_data;
            resp_valid <= 1'b1;
            state      <= ST_RESP;
          end
`else
          resp_rdata <= load_data;
          resp_valid <= 1'b1;
          state      <= ST_RESP;
`endif
        end

`ifdef LSU_MISALIGN_EN
        ST_LOAD_HI: begin
          resp_rdata <= load_data;
          resp_valid <= 1'b1;
          state      <= ST_RESP;
        end
`endif

        // The merged word is registered so the write cycle never depends on mem_rd.
        ST_RMW_READ: begin
          mem_we <= 1'b1;
          mem_wd <= merged;
          state  <= ST_RMW_WRITE;
        end

        ST_WRITE, ST_RMW_WRITE: begin
          mem_we     <= 1'b0;
          mem_wd     <= '0;
          resp_rdata <= '0;
          resp_valid <= 1'b1;
          state      <= ST_RESP;
        end

        ST_RESP: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
          req_ready  <= 1'b1;
          state      <= ST_IDLE;
        end

        default: begin
          mem_we    <= 1'b0;
          mem_wd    <= '0;
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: byte-addressed reference model, word-only memory model.
// Honours LSU_MISALIGN_EN when the design is built with it.
module tb_load_store_unit;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic        mem_we;
  logic [31:0] mem_rd;

  load_store_unit #(.DEPTH_WORDS(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_a      (mem_a),
    .mem_wd     (mem_wd),
    .mem_we     (mem_we),
    .mem_rd     (mem_rd)
  );

  always #5 clk = ~clk;

  // Word-only data memory with a backdoor port used for preloading.
  logic [31:0] mem [DEPTH];
  logic        bd_we = 1'b0;
  logic [9:0]  bd_idx = '0;
  logic [31:0] bd_data = '0;

  assign mem_rd = (mem_a < 32'(DEPTH)) ? mem[mem_a[9:0]] : 32'h0;

  always @(posedge clk) begin
    if (bd_we) mem[bd_idx] <= bd_data;
    else if (mem_we && (mem_a < 32'(DEPTH))) mem[mem_a[9:0]] <= mem_wd;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          wecnt;
    int          acc;
  } exp_t;

  exp_t sb[$];
  logic [31:0] ref_mem [DEPTH];

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    logic [31:0] w;
    w = ref_mem[a[11:2]];
    return w[a[1:0]*8 +: 8];
  endfunction

  task automatic wr_byte(input logic [31:0] a, input logic [7:0] b);
    logic [31:0] w;
    w = ref_mem[a[11:2]];
    w[a[1:0]*8 +: 8] = b;
    ref_mem[a[11:2]] = w;
  endtask

  // Reference: byte-addressed view of memory, RV32I semantics from funct3 alone.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output exp_t e);
    int  size;
    bit  unsup, mis, err;
    logic [31:0] idx, val;
    unsup = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && (f3 == 3'd4 || f3 == 3'd5));
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    idx   = addr / 4;
    mis   = (addr % size) != 0;
    err   = unsup || (idx >= DEPTH);
`ifdef LSU_MISALIGN_EN
    if (mis && we) err = 1;
    if (mis && !we && (idx + 1 >= DEPTH)) err = 1;
`else
    if (mis) err = 1;
`endif
    e = '{rdata: 32'h0, err: err, lat: 1, wecnt: 0, acc: 0};
    if (err) return;
    if (!we) begin
      val = 32'h0;
      for (int i = 0; i < size; i++) val[i*8 +: 8] = rd_byte(addr + i);
      if (f3 == 3'd0 && val[7])  val[31:8]  = 24'hFFFFFF;
      if (f3 == 3'd1 && val[15]) val[31:16] = 16'hFFFF;
      e.rdata = val;
      e.lat   = mis ? 3 : 2;
    end else begin
      for (int i = 0; i < size; i++) wr_byte(addr + i, wdata[i*8 +: 8]);
      e.lat   = (size == 4) ? 2 : 3;
      e.wecnt = 1;
    end
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata);
    exp_t e;
    int   t;
    t = 0;
    @(negedge clk);
    while (!req_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("req_ready_before_issue", {31'h0, req_ready}, 32'h1);
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    req_valid  = 1'b1;
    model(we, f3, addr, wdata, e);
    @(posedge clk);
    #1;
    e.acc = cyc;
    sb.push_back(e);
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
  endtask

  // Monitor: counts write cycles and compares each response against the scoreboard.
  int we_cnt = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!mem_we) check("mem_wd_idle", mem_wd, 32'h0);
    if (mem_we) we_cnt++;
    if (resp_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_resp", 32'h1, 32'h0);
      end else begin
        e = sb.pop_front();
        check("resp_rdata", resp_rdata, e.rdata);
        check("resp_err", {31'h0, resp_err}, {31'h0, e.err});
        check("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
        check("mem_we_cycles", 32'(we_cnt), 32'(e.wecnt));
      end
      we_cnt = 0;
    end
  end

  initial begin
    logic [31:0] w;
    logic [31:0] a;
    logic [2:0]  f;
    int          t;

    // Preload words 0..15 during reset, word1 fixed.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      w = (i == 1) ? 32'h8899AABB : $urandom;
      bd_we = 1'b1; bd_idx = 10'(i); bd_data = w;
      ref_mem[i] = w;
    end
    @(negedge clk);
    bd_we = 1'b0;

    check("rst_req_ready", {31'h0, req_ready}, 32'h1);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_resp_err", {31'h0, resp_err}, 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_mem_we", {31'h0, mem_we}, 32'h0);
    check("rst_mem_a", mem_a, 32'h0);
    check("rst_mem_wd", mem_wd, 32'h0);
    rst_n = 1'b1;

    issue(1'b0, 3'b000, 32'h5, 32'h0);          // LB
    issue(1'b0, 3'b100, 32'h5, 32'h0);          // LBU
    issue(1'b0, 3'b101, 32'h6, 32'h0);          // LHU
    issue(1'b1, 3'b000, 32'h6, 32'h11);         // SB
    issue(1'b1, 3'b010, 32'h8, 32'h44332211);   // SW
    issue(1'b0, 3'b010, 32'h8, 32'h0);          // LW
    issue(1'b0, 3'b010, 32'h6, 32'h0);          // misaligned LW
    issue(1'b0, 3'b010, 32'h1000, 32'h0);       // out of range
    issue(1'b0, 3'b011, 32'h0, 32'h0);          // unsupported
    issue(1'b0, 3'b010, 32'h4, 32'h0);
    issue(1'b1, 3'b001, 32'h1, 32'h1234);       // misaligned SH
    issue(1'b1, 3'b100, 32'h4, 32'h0);          // SBU is unsupported

    // SH aborted by reset in RMW_READ: no write may reach memory.
    t = 0;
    @(negedge clk);
    while (!req_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("req_ready_before_abort", {31'h0, req_ready}, 32'h1);
    req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h4; req_wdata = 32'hBEEF;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("abort_mem_we", {31'h0, mem_we}, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_req_ready", {31'h0, req_ready}, 32'h1);
    check("abort_we_cnt", 32'(we_cnt), 32'h0);
    issue(1'b0, 3'b010, 32'h4, 32'h0);          // word1 unchanged

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 4))
          0: f = 3'b000;
          1: f = 3'b001;
          2: f = 3'b010;
          3: f = 3'b100;
          default: f = 3'b101;
        endcase
      end else begin
        f = 3'($urandom);
      end
      if ($urandom_range(0, 9) == 0) a = $urandom | 32'h1000;
      else a = 32'($urandom_range(0, 14) * 4 + $urandom_range(0, 3));
      issue(1'($urandom), f, a, $urandom);
    end

    t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    for (int i = 0; i < 16; i++) check("final_mem", mem[i], ref_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
